// File: rtl/div.sv
// Multi-cycle 32-bit radix-2 restoring divider for DIV/DIVU.
// Result packs {remainder, quotient}; ready stays up until the requester drops start_i.
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        ST_FREE,
        ST_DIVZERO,
        ST_ON,
        ST_END
    } state_t;

    state_t      state_reg;
    logic [5:0]  cnt_reg;
    logic [64:0] dividend_reg;
    logic [31:0] divisor_reg;
    logic        signed_reg;
    logic        op1_neg_reg;
    logic        op2_neg_reg;
    logic [63:0] result_reg;
    logic        ready_reg;

    logic [31:0] op1_abs;
    logic [31:0] op2_abs;
    logic [32:0] diff;
    logic [31:0] quot_raw;
    logic [31:0] rem_raw;
    logic [31:0] quot_fin;
    logic [31:0] rem_fin;

    // Magnitudes are taken from the live inputs; they only matter on the latch edge.
    always_comb begin
        op1_abs  = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
        op2_abs  = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
        diff     = {1'b0, dividend_reg[63:32]} - {1'b0, divisor_reg};
        quot_raw = dividend_reg[31:0];
        rem_raw  = dividend_reg[64:33];
        quot_fin = (signed_reg && (op1_neg_reg ^ op2_neg_reg)) ? (~quot_raw + 32'd1) : quot_raw;
        rem_fin  = (signed_reg && op1_neg_reg) ? (~rem_raw + 32'd1) : rem_raw;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= ST_FREE;
            cnt_reg      <= 6'd0;
            dividend_reg <= 65'd0;
            divisor_reg  <= 32'd0;
            signed_reg   <= 1'b0;
            op1_neg_reg  <= 1'b0;
            op2_neg_reg  <= 1'b0;
            result_reg   <= 64'd0;
            ready_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_FREE: begin
                    ready_reg  <= 1'b0;
                    result_reg <= 64'd0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == 32'd0) begin
                            state_reg <= ST_DIVZERO;
                        end else begin
                            state_reg    <= ST_ON;
                            cnt_reg      <= 6'd0;
                            divisor_reg  <= op2_abs;
                            dividend_reg <= {32'd0, op1_abs, 1'b0};
                            signed_reg   <= signed_div_i;
                            op1_neg_reg  <= opdata1_i[31];
                            op2_neg_reg  <= opdata2_i[31];
                        end
                    end
                end
                ST_DIVZERO: begin
                    if (annul_i) begin
                        state_reg <= ST_FREE;
                        cnt_reg   <= 6'd0;
                    end else begin
                        state_reg  <= ST_END;
                        result_reg <= 64'd0;
                    end
                end
                ST_ON: begin
                    if (annul_i) begin
                        state_reg <= ST_FREE;
                        cnt_reg   <= 6'd0;
                    end else if (cnt_reg != 6'd32) begin
                        // Restore by simply shifting when the trial subtraction borrows.
                        if (diff[32]) begin
                            dividend_reg <= {dividend_reg[63:0], 1'b0};
                        end else begin
                            dividend_reg <= {diff[31:0], dividend_reg[31:0], 1'b1};
                        end
                        cnt_reg <= cnt_reg + 6'd1;
                    end else begin
                        result_reg <= {rem_fin, quot_fin};
                        ready_reg  <= 1'b1;
                        state_reg  <= ST_END;
                        cnt_reg    <= 6'd0;
                    end
                end
                ST_END: begin
                    // annul_i is deliberately ignored here; only start_i releases the result.
                    if (start_i) begin
                        ready_reg <= 1'b1;
                    end else begin
                        state_reg  <= ST_FREE;
                        ready_reg  <= 1'b0;
                        result_reg <= 64'd0;
                    end
                end
                default: begin
                    state_reg <= ST_FREE;
                end
            endcase
        end
    end

    assign result_o = result_reg;
    assign ready_o  = ready_reg;

endmodule

// File: tb/tb_div.sv
// Directed bench for the div block: latency, results, hold/clear handshake, annul, reset and operand isolation.
module tb_div;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_checks = 0;
    int n_fails  = 0;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = sgn;
        start_i      = 1'b1;
    endtask

    // Counts edges from the start edge until ready_o is seen; latency excludes the start edge.
    task automatic wait_ready(input string tag, input int exp_lat, input logic [63:0] exp_res,
                              input bit scramble);
        int edges;
        edges = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            edges++;
            if (scramble) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = 1'($urandom_range(0, 1));
            end
            if (ready_o) break;
        end
        check({tag, " latency"}, 64'(edges - 1), 64'(exp_lat));
        check({tag, " result"}, result_o, exp_res);
        $display("op %s: result=%h latency=%0d", tag, result_o, edges - 1);
    endtask

    task automatic hold_and_release(input string tag, input logic [63:0] exp_res);
        repeat (3) @(negedge clk);
        check({tag, " hold ready"}, 64'(ready_o), 64'd1);
        check({tag, " hold result"}, result_o, exp_res);
        start_i = 1'b0;
        @(negedge clk);
        check({tag, " clear ready"}, 64'(ready_o), 64'd0);
        check({tag, " clear result"}, result_o, 64'd0);
    endtask

    initial begin
        bit seen_ready;

        rst          = 1'b0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        repeat (3) @(negedge clk);
        check("reset ready", 64'(ready_o), 64'd0);
        check("reset result", result_o, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Unsigned 100 / 7 = 14 r 2
        issue(32'd100, 32'd7, 1'b0);
        wait_ready("u100/7", 33, {32'd2, 32'd14}, 1'b0);
        hold_and_release("u100/7", {32'd2, 32'd14});

        // Signed -7 / 2 = -3 r -1
        issue(32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_ready("s-7/2", 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
        hold_and_release("s-7/2", {32'hFFFF_FFFF, 32'hFFFF_FFFD});

        // Signed overflow case wraps without trapping
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_ready("sMIN/-1", 33, {32'd0, 32'h8000_0000}, 1'b0);
        hold_and_release("sMIN/-1", {32'd0, 32'h8000_0000});

        // Divide by zero
        issue(32'h1234_5678, 32'd0, 1'b0);
        wait_ready("divzero", 2, 64'd0, 1'b0);
        hold_and_release("divzero", 64'd0);

        // Annul at iteration 10 of 0xFFFFFFFF / 3
        issue(32'hFFFF_FFFF, 32'd3, 1'b0);
        repeat (10) @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        annul_i    = 1'b0;
        seen_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            seen_ready |= ready_o;
        end
        check("annul no ready", 64'(seen_ready), 64'd0);
        check("annul result", result_o, 64'd0);
        issue(32'd9, 32'd3, 1'b0);
        wait_ready("u9/3", 33, {32'd0, 32'd3}, 1'b0);
        hold_and_release("u9/3", {32'd0, 32'd3});

        // Reset at iteration 20, restart with start_i held high
        issue(32'd7, 32'd7, 1'b0);
        repeat (21) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst ready", 64'(ready_o), 64'd0);
        check("midrst result", result_o, 64'd0);
        rst = 1'b1;
        issue(32'd1000, 32'd10, 1'b0);
        wait_ready("u1000/10", 33, {32'd0, 32'd100}, 1'b0);
        hold_and_release("u1000/10", {32'd0, 32'd100});

        // Operands scrambled every cycle after the latch edge
        issue(32'd50, 32'd5, 1'b0);
        wait_ready("u50/5 scr", 33, {32'd0, 32'd10}, 1'b1);
        hold_and_release("u50/5 scr", {32'd0, 32'd10});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
